// File: rtl/aes_pkg.sv
// Shared AES definitions: block/index sizes, round-engine FSM encoding and
// the GF(2^8) doubling helper.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int BLOCK_W   = 128;
  localparam int KIDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL,
    DONE
  } dre_state_e;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey: bitwise XOR of the state with the round key.
module add_round_key
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] round_key,
  output logic [BLOCK_W-1:0] state_out
);

  assign state_out = state_in ^ round_key;

endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns: each column multiplied by the circulant {0e,0b,0d,09}.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  output logic [BLOCK_W-1:0] state_out
);

  // Constant multiply by a 4-bit coefficient built from x, x^2, x^3 terms
  function automatic logic [7:0] mul_c(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2, a4, a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return (c[0] ? a  : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
           (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state_in[127-32*c -: 8];
    assign a1 = state_in[119-32*c -: 8];
    assign a2 = state_in[111-32*c -: 8];
    assign a3 = state_in[103-32*c -: 8];
    assign state_out[127-32*c -: 8] = mul_c(a0, 4'he) ^ mul_c(a1, 4'hb) ^ mul_c(a2, 4'hd) ^ mul_c(a3, 4'h9);
    assign state_out[119-32*c -: 8] = mul_c(a0, 4'h9) ^ mul_c(a1, 4'he) ^ mul_c(a2, 4'hb) ^ mul_c(a3, 4'hd);
    assign state_out[111-32*c -: 8] = mul_c(a0, 4'hd) ^ mul_c(a1, 4'h9) ^ mul_c(a2, 4'he) ^ mul_c(a3, 4'hb);
    assign state_out[103-32*c -: 8] = mul_c(a0, 4'hb) ^ mul_c(a1, 4'hd) ^ mul_c(a2, 4'h9) ^ mul_c(a3, 4'he);
  end

endmodule

// File: rtl/inv_shift_rows.sv
// InvShiftRows: row r rotated right by r columns. Byte i is bits [127-8i -: 8],
// row = i % 4, column = i / 4.
module inv_shift_rows
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  output logic [BLOCK_W-1:0] state_out
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_out[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes computed arithmetically: inverse affine map, then GF(2^8)
// multiplicative inverse as b^254 (0 maps to 0).
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  output logic [BLOCK_W-1:0] state_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b, x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    b    = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    x2   = gf_mul(b, b);
    x3   = gf_mul(x2, b);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign state_out[127-8*i -: 8] = inv_sbox(state_in[127-8*i -: 8]);
  end

endmodule

// File: rtl/decrypt_round_engine.sv
// Iterative AES inverse-cipher core: nine middle rounds one per cycle, then
// the final AddRoundKey(k0), with valid/ready on both sides.
module decrypt_round_engine #(
  parameter int NR     = aes_pkg::NR_AES128,
  parameter int KIDX_W = aes_pkg::KIDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [aes_pkg::BLOCK_W-1:0] state_in,
  output logic [KIDX_W-1:0]           key_idx,
  input  logic [aes_pkg::BLOCK_W-1:0] round_key,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [aes_pkg::BLOCK_W-1:0] state_out
);
  import aes_pkg::*;

  dre_state_e         state_q, state_nxt;
  logic [KIDX_W-1:0]  round_cnt;
  logic [BLOCK_W-1:0] state_reg;
  logic [BLOCK_W-1:0] ark_out, imc_out, isr_out, isb_out;
  logic               load_in, run_step, fin_step, out_clr;

  // Round datapath: ARK -> InvMixColumns -> InvShiftRows -> InvSubBytes
  add_round_key   u_ark (.state_in(state_reg), .round_key(round_key), .state_out(ark_out));
  inv_mix_columns u_imc (.state_in(ark_out),   .state_out(imc_out));
  inv_shift_rows  u_isr (.state_in(imc_out),   .state_out(isr_out));
  inv_sub_bytes   u_isb (.state_in(isr_out),   .state_out(isb_out));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    key_idx   = KIDX_W'(NR-1);
    load_in   = 1'b0;
    run_step  = 1'b0;
    fin_step  = 1'b0;
    out_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_in   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        key_idx  = round_cnt;
        run_step = 1'b1;
        if (round_cnt == KIDX_W'(1)) state_nxt = FINAL;
      end
      FINAL: begin
        key_idx   = '0;
        fin_step  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round state / output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      round_cnt <= '0;
      state_out <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_in) begin
        state_reg <= state_in;
        round_cnt <= KIDX_W'(NR-1);
      end
      if (run_step) begin
        state_reg <= isb_out;
        round_cnt <= round_cnt - KIDX_W'(1);
      end
      if (fin_step) begin
        state_out <= ark_out;
        out_valid <= 1'b1;
      end
      if (out_clr) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decrypt_round_engine.sv
// Bench for decrypt_round_engine: a table-driven forward AES model produces
// ciphertexts and round keys; the engine must recover the plaintext.
module tb_decrypt_round_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [127:0] state_in = '0;
  logic [127:0] round_key, state_out;
  logic [3:0]   key_idx;
  logic [127:0] imc_in = '0;
  logic [127:0] imc_out;

  logic [127:0] rk [0:10];
  logic [7:0]   sbox  [0:255];
  logic [7:0]   isbox [0:255];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int           acc_q [$];
  logic [127:0] out_q [$];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  decrypt_round_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .key_idx(key_idx), .round_key(round_key),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
  );

  inv_mix_columns u_imc (.state_in(imc_in), .state_out(imc_out));

  always #5 clk = ~clk;

  // Key schedule store: combinational lookup by index
  always_comb begin
    round_key = '0;
    if (key_idx <= 4'd10) round_key = rk[key_idx];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready)   acc_q.push_back(cyc);
    if (!rst && out_valid && out_ready) out_q.push_back(state_out);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] p;
    p = 8'h00;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x[7:0];
      x = x << 1;
      if (x[8]) x ^= 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[gb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] m_isub(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[gb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c+r)%4));
    return o;
  endfunction

  // Undo m_shift by scattering each byte back to where it came from
  function automatic logic [127:0] m_ishift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = gb(s, r + 4*c);
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j-r+4)%4], gb(s, j + 4*c));
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = m_mix(m_shift(m_sub(s))) ^ rk[r];
    return m_shift(m_sub(s)) ^ rk[10];
  endfunction

  // What the initial decrypt stage hands to the engine
  function automatic logic [127:0] m_prep(input logic [127:0] ct);
    return m_isub(m_ishift(ct ^ rk[10]));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the engine idle; returns clocks from the accept
  // edge to out_valid and the key indices requested in between.
  task automatic send_and_wait(input logic [127:0] sin, output int lat, output logic [39:0] kseq);
    state_in = sin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = rnd128();
    lat  = 0;
    kseq = '0;
    while (!out_valid && lat < 40) begin
      if (lat < 10) kseq[39-4*lat -: 4] = key_idx;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input string tag);
    int          lat;
    logic [39:0] ks;
    expand(key);
    send_and_wait(m_prep(m_encrypt(pt)), lat, ks);
    check({tag, "_lat"}, 128'(lat), 128'(10));
    check({tag, "_kseq"}, 128'(ks), 128'(40'h9876543210));
    check({tag, "_pt"}, state_out, pt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, 128'({in_ready, out_valid}), 128'(2'b10));
  endtask

  initial begin
    int           lat, n0, o0;
    logic [39:0]  ks;
    logic [127:0] x, pb, sa, sb, p2;
    logic [7:0]   inv, b;

    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[v]  = b;
      isbox[b] = 8'(v);
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_key_idx", 128'(key_idx), 128'(9));
    check("rst_state_out", state_out, 128'h0);
    rst = 1'b0;

    // InvMixColumns on the FIPS-197 round-1 MixColumns output
    imc_in = 128'h046681e5e0cb199a48f8d37a2806264c;
    #1;
    check("imc_col0", 128'(imc_out[127:96]), 128'(32'hd4bf5d30));
    check("imc_col1", 128'(imc_out[95:64]),  128'(32'he0b452ae));
    check("imc_col2", 128'(imc_out[63:32]),  128'(32'hb84111f1));
    check("imc_col3", 128'(imc_out[31:0]),   128'(32'h1e2798e5));
    x = rnd128();
    imc_in = m_mix(x);
    #1;
    check("imc_rand", imc_out, x);

    // FIPS-197 C.1 with backpressure
    expand(C1_KEY);
    check("model_c1_ct", m_encrypt(C1_PT), C1_CT);
    @(negedge clk);
    send_and_wait(m_prep(C1_CT), lat, ks);
    check("c1_lat", 128'(lat), 128'(10));
    check("c1_kseq", 128'(ks), 128'(40'h9876543210));
    check("c1_pt", state_out, C1_PT);
    n0 = acc_q.size();
    for (int i = 0; i < 20; i++) begin
      if (i == 7) begin
        in_valid = 1'b1;
        state_in = rnd128();
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_state_out", state_out, C1_PT);
      check("bp_flags", 128'({out_valid, in_ready}), 128'(2'b10));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_idle", 128'({in_ready, out_valid}), 128'(2'b10));
    check("bp_no_accept", 128'(acc_q.size() - n0), 128'(0));

    // Back-to-back blocks, out_ready tied high
    pb = rnd128();
    sa = m_prep(C1_CT);
    sb = m_prep(m_encrypt(pb));
    n0 = acc_q.size();
    o0 = out_q.size();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = sa;
    for (int i = 0; i < 40 && acc_q.size() < n0 + 1; i++) @(negedge clk);
    state_in = sb;
    for (int i = 0; i < 40 && acc_q.size() < n0 + 2; i++) @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && out_q.size() < o0 + 2; i++) @(negedge clk);
    out_ready = 1'b0;
    check("b2b_n_out", 128'(out_q.size() - o0), 128'(2));
    check("b2b_pt1", (out_q.size() > o0) ? out_q[o0] : 128'hx, C1_PT);
    check("b2b_pt2", (out_q.size() > o0 + 1) ? out_q[o0+1] : 128'hx, pb);
    // Period: accept + 9 RUN + FINAL + DONE edges before the next IDLE accept
    check("b2b_gap", (acc_q.size() > n0 + 1) ? 128'(acc_q[n0+1] - acc_q[n0]) : 128'hx, 128'(12));

    // Randomized keys and plaintexts
    for (int t = 0; t < 4; t++) run_block(rnd128(), rnd128(), "rand");

    // Asynchronous reset in the middle of RUN
    expand(rnd128());
    state_in = m_prep(m_encrypt(rnd128()));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && key_idx != 4'd5; i++) @(negedge clk);
    check("rstmid_at_round5", 128'(key_idx), 128'(5));
    #2 rst = 1'b1;
    #1;
    check("rstmid_out_valid", 128'(out_valid), 128'(0));
    check("rstmid_state_out", state_out, 128'h0);
    check("rstmid_in_ready", 128'(in_ready), 128'(1));
    check("rstmid_key_idx", 128'(key_idx), 128'(9));
    @(negedge clk);
    rst = 1'b0;
    run_block(rnd128(), rnd128(), "post_rst");

    // in_valid and out_ready together in DONE
    expand(rnd128());
    x = rnd128();
    send_and_wait(m_prep(m_encrypt(x)), lat, ks);
    check("dual_first_pt", state_out, x);
    expand(rnd128());
    p2 = rnd128();
    n0 = acc_q.size();
    state_in  = m_prep(m_encrypt(p2));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("dual_no_accept_in_done", 128'(acc_q.size() - n0), 128'(0));
    check("dual_idle", 128'({in_ready, out_valid}), 128'(2'b10));
    send_and_wait(state_in, lat, ks);
    check("dual_accepted", 128'(acc_q.size() - n0), 128'(1));
    check("dual_lat", 128'(lat), 128'(10));
    check("dual_second_pt", state_out, p2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
